// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults and receiver FSM state type for the VGA
// sync receiver.
package vga_timing_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int H_FP         = 16;
    localparam int H_SYNC       = 96;
    localparam int H_BP         = 48;
    localparam int V_ACTIVE     = 480;
    localparam int V_FP         = 10;
    localparam int V_SYNC       = 2;
    localparam int V_BP         = 33;
    localparam int LOCK_LINES   = 4;
    localparam int UNLOCK_LINES = 2;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Active window measured from the sync falling edge (sync comes first in a line).
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_SYNC + H_BP + H_ACTIVE - 1;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_SYNC + V_BP + V_ACTIVE - 1;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } sync_state_e;

endpackage

// File: rtl/sync_fall_detect.sv
// Two-flop synchroniser for an asynchronous level, followed by a falling-edge
// detector built only from registered values.
module sync_fall_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchroniser chain plus one-cycle history of the synchronised level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    // Registers reset low, so a line held low through reset never fakes an edge.
    assign fall = prev_r & ~sync_r;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel coordinates and data-enable from raw
// active-low hsync/vsync and tracks line-period lock.
module vga_sync_receiver #(
    parameter int H_ACTIVE     = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP         = vga_timing_pkg::H_FP,
    parameter int H_SYNC       = vga_timing_pkg::H_SYNC,
    parameter int H_BP         = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE     = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP         = vga_timing_pkg::V_FP,
    parameter int V_SYNC       = vga_timing_pkg::V_SYNC,
    parameter int V_BP         = vga_timing_pkg::V_BP,
    parameter int LOCK_LINES   = vga_timing_pkg::LOCK_LINES,
    parameter int UNLOCK_LINES = vga_timing_pkg::UNLOCK_LINES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       de,
    output logic       line_start,
    output logic       frame_start,
    output logic       locked,
    output logic       h_err
);

    import vga_timing_pkg::*;

    localparam int H_TOTAL_L = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_L = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] CNT_MAX     = 10'd1023;
    localparam logic [9:0] H_LAST      = 10'(H_TOTAL_L - 1);
    localparam logic [9:0] H_START     = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END       = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0] V_START     = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END       = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
    localparam logic [3:0] LOCK_LAST   = 4'(LOCK_LINES - 1);
    localparam logic [3:0] UNLOCK_LAST = 4'(UNLOCK_LINES - 1);

    // The 1023 saturation value doubles as the timeout marker, so a real line must end below it.
    if (H_TOTAL_L > 1022 || V_TOTAL_L > 1023) begin : g_timing_too_large
        $error("vga_sync_receiver: H/V totals do not fit the 10-bit counters");
    end

    logic        h_fall_s;
    logic        v_fall_s;
    logic [9:0]  h_cnt_r;
    logic [9:0]  v_cnt_r;
    logic        vs_pend_r;
    sync_state_e state_r;
    sync_state_e state_s;
    logic [3:0]  good_cnt_r;
    logic [3:0]  good_cnt_s;
    logic [3:0]  bad_cnt_r;
    logic [3:0]  bad_cnt_s;
    logic        locked_r;
    logic        locked_s;
    logic        h_err_r;
    logic        h_err_s;
    logic        line_start_r;
    logic        frame_start_r;
    logic [9:0]  pix_x_r;
    logic [9:0]  pix_y_r;
    logic        de_r;
    logic        line_good_s;
    logic        timeout_s;
    logic        in_win_s;

    sync_fall_detect u_hsync_fall (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (hsync),
        .fall     (h_fall_s)
    );

    sync_fall_detect u_vsync_fall (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (vsync),
        .fall     (v_fall_s)
    );

    assign line_good_s = (h_cnt_r == H_LAST);
    // Timeout fires on the edge where h_cnt would step onto its saturation value.
    assign timeout_s   = !h_fall_s && (h_cnt_r == (CNT_MAX - 10'd1));
    assign in_win_s    = (h_cnt_r >= H_START) && (h_cnt_r <= H_END) &&
                         (v_cnt_r >= V_START) && (v_cnt_r <= V_END);

    // Horizontal position counter, restarted on every hsync edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r      <= 10'd0;
            line_start_r <= 1'b0;
        end else begin
            line_start_r <= h_fall_s;
            if (h_fall_s) begin
                h_cnt_r <= 10'd0;
            end else if (h_cnt_r != CNT_MAX) begin
                h_cnt_r <= h_cnt_r + 10'd1;
            end else begin
                h_cnt_r <= h_cnt_r;
            end
        end
    end

    // Vertical line counter; a vsync edge is held pending until the next line start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_cnt_r       <= 10'd0;
            vs_pend_r     <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (h_fall_s) begin
            if (vs_pend_r || v_fall_s) begin
                v_cnt_r       <= 10'd0;
                vs_pend_r     <= 1'b0;
                frame_start_r <= 1'b1;
            end else begin
                v_cnt_r       <= (v_cnt_r == CNT_MAX) ? CNT_MAX : (v_cnt_r + 10'd1);
                vs_pend_r     <= 1'b0;
                frame_start_r <= 1'b0;
            end
        end else begin
            v_cnt_r       <= v_cnt_r;
            vs_pend_r     <= vs_pend_r | v_fall_s;
            frame_start_r <= 1'b0;
        end
    end

    // Lock FSM state and line-quality counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= SEARCH;
            good_cnt_r <= 4'd0;
            bad_cnt_r  <= 4'd0;
            locked_r   <= 1'b0;
            h_err_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            good_cnt_r <= good_cnt_s;
            bad_cnt_r  <= bad_cnt_s;
            locked_r   <= locked_s;
            h_err_r    <= h_err_s;
        end
    end

    // Lock FSM next-state: period check on every hsync edge, timeout drops to SEARCH.
    always_comb begin
        state_s    = state_r;
        good_cnt_s = good_cnt_r;
        bad_cnt_s  = bad_cnt_r;
        h_err_s    = 1'b0;
        case (state_r)
            SEARCH: begin
                if (h_fall_s) begin
                    good_cnt_s = 4'd0;
                    bad_cnt_s  = 4'd0;
                    state_s    = ACQUIRE;
                end else begin
                    state_s = SEARCH;
                end
            end
            ACQUIRE: begin
                if (timeout_s) begin
                    h_err_s    = 1'b1;
                    good_cnt_s = 4'd0;
                    state_s    = SEARCH;
                end else if (h_fall_s) begin
                    if (line_good_s) begin
                        good_cnt_s = good_cnt_r + 4'd1;
                        if (good_cnt_r == LOCK_LAST) begin
                            bad_cnt_s = 4'd0;
                            state_s   = LOCKED;
                        end else begin
                            state_s = ACQUIRE;
                        end
                    end else begin
                        h_err_s    = 1'b1;
                        good_cnt_s = 4'd0;
                    end
                end else begin
                    state_s = ACQUIRE;
                end
            end
            LOCKED: begin
                if (timeout_s) begin
                    h_err_s    = 1'b1;
                    good_cnt_s = 4'd0;
                    bad_cnt_s  = 4'd0;
                    state_s    = SEARCH;
                end else if (h_fall_s) begin
                    if (line_good_s) begin
                        bad_cnt_s = 4'd0;
                    end else begin
                        h_err_s = 1'b1;
                        if (bad_cnt_r == UNLOCK_LAST) begin
                            bad_cnt_s  = 4'd0;
                            good_cnt_s = 4'd0;
                            state_s    = ACQUIRE;
                        end else begin
                            bad_cnt_s = bad_cnt_r + 4'd1;
                        end
                    end
                end else begin
                    state_s = LOCKED;
                end
            end
            default: begin
                good_cnt_s = 4'd0;
                bad_cnt_s  = 4'd0;
                state_s    = SEARCH;
            end
        endcase
        locked_s = (state_s == LOCKED);
    end

    // Output stage: coordinates and data-enable lag the counters by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x_r <= 10'd0;
            pix_y_r <= 10'd0;
            de_r    <= 1'b0;
        end else if (in_win_s) begin
            pix_x_r <= h_cnt_r - H_START;
            pix_y_r <= v_cnt_r - V_START;
            de_r    <= locked_r;
        end else begin
            pix_x_r <= 10'd0;
            pix_y_r <= 10'd0;
            de_r    <= 1'b0;
        end
    end

    assign pix_x       = pix_x_r;
    assign pix_y       = pix_y_r;
    assign de          = de_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign locked      = locked_r;
    assign h_err       = h_err_r;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver: a 640x480 stream generator feeds the
// DUT while scoreboards check pixels, line/frame pulses, lock and errors.
module tb_vga_sync_receiver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync = 1'b1;
    logic       vsync = 1'b1;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       de;
    logic       line_start;
    logic       frame_start;
    logic       locked;
    logic       h_err;

    vga_sync_receiver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .de          (de),
        .line_start  (line_start),
        .frame_start (frame_start),
        .locked      (locked),
        .h_err       (h_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          hc = 0;
    int          vc = 0;
    int          line_len = 800;
    int          since = 0;
    int          herr_cnt = 0;
    int          drop_cnt = 0;
    bit          gen_on = 1'b0;
    bit          pix_en = 1'b0;
    bit          vs_early = 1'b0;
    bit          vpend = 1'b0;
    bit          hs_prev = 1'b1;
    bit          vs_prev = 1'b1;
    bit          de_q = 1'b0;
    bit          locked_q = 1'b0;
    logic [19:0] pix_q[$];
    bit          fs_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel clock: drive the generator, push expectations, then check DUT outputs.
    task automatic tick();
        bit hs;
        bit vs;
        if (gen_on) begin
            hs = (hc >= 96);
            if (vs_early)
                vs = !((vc == 524 && hc >= 400) || vc == 0 || (vc == 1 && hc < 400));
            else
                vs = (vc >= 2);
        end else begin
            hs = 1'b1;
            vs = 1'b1;
        end
        if (!vs && vs_prev) vpend = 1'b1;
        if (!hs && hs_prev) begin
            fs_q.push_back(vpend);
            vpend = 1'b0;
            since = 0;
        end else begin
            since++;
        end
        hs_prev = hs;
        vs_prev = vs;
        if (gen_on && pix_en && hc >= 144 && hc <= 783 && vc >= 35 && vc <= 514)
            pix_q.push_back({10'(hc - 144), 10'(vc - 35)});
        hsync = hs;
        vsync = vs;
        if (gen_on) begin
            hc++;
            if (hc == line_len) begin
                hc = 0;
                vc = (vc == 524) ? 0 : vc + 1;
            end
        end
        @(posedge clk);
        #1;
        if (de) begin
            if (pix_q.size() == 0) begin
                chk("de_unexpected", 32'(de), 32'd0);
            end else begin
                logic [19:0] e;
                e = pix_q.pop_front();
                chk("pix_x", 32'(pix_x), 32'(e[19:10]));
                chk("pix_y", 32'(pix_y), 32'(e[9:0]));
            end
            if (!de_q) chk("de_rise_latency", 32'(since), 32'd147);
        end
        if (line_start) begin
            if (fs_q.size() == 0) chk("line_start_unexpected", 32'(line_start), 32'd0);
            else chk("frame_start", 32'(frame_start), 32'(fs_q.pop_front()));
        end else if (frame_start) begin
            chk("frame_start_orphan", 32'(frame_start), 32'd0);
        end
        if (h_err) herr_cnt++;
        if (locked_q && !locked) drop_cnt++;
        de_q = de;
        locked_q = locked;
    endtask

    task automatic run_clocks(input int n);
        repeat (n) tick();
    endtask

    task automatic run_line(input int len);
        line_len = len;
        run_clocks(len);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix_x"}, 32'(pix_x), 32'd0);
        chk({tag, "_pix_y"}, 32'(pix_y), 32'd0);
        chk({tag, "_de"}, 32'(de), 32'd0);
        chk({tag, "_line_start"}, 32'(line_start), 32'd0);
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_h_err"}, 32'(h_err), 32'd0);
    endtask

    initial begin
        int herr0;
        int drop0;

        // Reset state with idle syncs.
        run_clocks(4);
        chk_all_zero("reset");
        rst_n = 1'b1;
        run_clocks(4);
        chk("idle_locked", 32'(locked), 32'd0);

        // Nominal stream from line 524 with vsync falling mid-line; lock on the 5th edge.
        gen_on = 1'b1;
        pix_en = 1'b1;
        vs_early = 1'b1;
        hc = 0;
        vc = 524;
        repeat (4) run_line(800);
        line_len = 800;
        run_clocks(2);
        chk("lock_before_5th_edge", 32'(locked), 32'd0);
        run_clocks(1);
        chk("lock_after_5th_edge", 32'(locked), 32'd1);
        run_clocks(797);
        repeat (34) run_line(800);
        chk("pixels_drained_frame", 32'(pix_q.size()), 32'd0);
        chk("no_herr_nominal", 32'(herr_cnt), 32'd0);

        // vsync falling in the same cycle as hsync.
        vs_early = 1'b0;
        vc = 0;
        repeat (3) run_line(800);
        chk("locked_after_sameclk_vs", 32'(locked), 32'd1);

        // Single 799-clock line while locked.
        herr0 = herr_cnt;
        drop0 = drop_cnt;
        run_line(799);
        run_line(800);
        chk("short_line_herr", 32'(herr_cnt - herr0), 32'd1);
        chk("short_line_no_drop", 32'(drop_cnt - drop0), 32'd0);
        chk("short_line_locked", 32'(locked), 32'd1);
        run_line(800);

        // Two consecutive 801-clock lines unlock; relock from ACQUIRE after 4 good lines.
        herr0 = herr_cnt;
        run_line(801);
        run_line(801);
        line_len = 800;
        run_clocks(2);
        chk("long_line_still_locked", 32'(locked), 32'd1);
        run_clocks(1);
        chk("long_line_unlocked", 32'(locked), 32'd0);
        chk("long_line_herr_pulse", 32'(h_err), 32'd1);
        run_clocks(797);
        repeat (3) run_line(800);
        line_len = 800;
        run_clocks(2);
        chk("acquire_relock_before", 32'(locked), 32'd0);
        run_clocks(1);
        chk("acquire_relock_after", 32'(locked), 32'd1);
        run_clocks(797);
        chk("long_line_herr_count", 32'(herr_cnt - herr0), 32'd2);

        // hsync held high for 1100 clocks: timeout at h_cnt == 1023, relock from SEARCH.
        herr0 = herr_cnt;
        line_len = 1100;
        run_clocks(1025);
        chk("timeout_before_locked", 32'(locked), 32'd1);
        chk("timeout_before_herr", 32'(h_err), 32'd0);
        run_clocks(1);
        chk("timeout_unlocked", 32'(locked), 32'd0);
        chk("timeout_herr_pulse", 32'(h_err), 32'd1);
        run_clocks(74);
        repeat (4) run_line(800);
        line_len = 800;
        run_clocks(2);
        chk("search_relock_before", 32'(locked), 32'd0);
        run_clocks(1);
        chk("search_relock_after", 32'(locked), 32'd1);
        run_clocks(797);
        chk("timeout_herr_count", 32'(herr_cnt - herr0), 32'd1);

        // Asynchronous reset mid-line, then reacquire from scratch.
        run_clocks(300);
        chk("pre_reset_locked", 32'(locked), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midline_reset");
        run_clocks(5);
        rst_n = 1'b1;
        fs_q.delete();
        pix_q.delete();
        vpend = 1'b0;
        locked_q = 1'b0;
        run_clocks(495);
        repeat (4) run_line(800);
        line_len = 800;
        run_clocks(2);
        chk("post_reset_lock_before", 32'(locked), 32'd0);
        run_clocks(1);
        chk("post_reset_lock_after", 32'(locked), 32'd1);
        run_clocks(797);

        chk("pixel_queue_empty", 32'(pix_q.size()), 32'd0);
        chk("line_queue_empty", 32'(fs_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive end of the VGA timing interface: samples the external active-low hsync/vsync pair and recovers the pixel coordinates and data-enable.
- Verifies the line period against the nominal line length and reports lock status.
- Sits downstream of the h/v counter timing generator (or any external 640x480@60 source), feeding capture or overlay logic.
- Clocked at pixel rate (25 MHz nominal).

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
LOCK_LINES, 4, consecutive good lines needed to lock
UNLOCK_LINES, 2, consecutive bad lines needed to drop lock

Ports:
clk  in  1  pixel clock, single clock domain
rst_n  in  1  asynchronous, active-low reset
hsync  in  1  raw active-low hsync, asynchronous to clk
vsync  in  1  raw active-low vsync, asynchronous to clk
pix_x  out  10  active-area column 0..639, 0 outside active
pix_y  out  10  active-area row 0..479, 0 outside active
de  out  1  data enable: locked and inside the active area
line_start  out  1  one-cycle pulse per detected hsync falling edge
frame_start  out  1  one-cycle pulse when v_cnt is loaded to 0
locked  out  1  lock status
h_err  out  1  one-cycle pulse on a bad line period or timeout

Behaviour:
- H_TOTAL = 800 and V_TOTAL = 525, both derived from the parameters.
- Reset: every output and internal register is 0; FSM enters SEARCH.
- Synchroniser: 2-flop synchroniser on each sync input, then a registered falling-edge detect.
  - Raw hsync sampled low at clock edge k (high at k-1) gives a line_start pulse and h_cnt == 0 after edge k+2.
- h_cnt: 10-bit counter, increments each clock and loads 0 on a hsync edge.
  - With no edge it saturates at 1023, which is a timeout.
- Period check: on each hsync edge, the line is good iff the pre-load h_cnt == H_TOTAL-1.
  - The first edge after SEARCH is not checked; it only starts counting.
- FSM:
  - SEARCH: on the first hsync edge, clear good_cnt and go to ACQUIRE.
  - ACQUIRE:
    - A good line increments good_cnt; on reaching LOCK_LINES, go to LOCKED (locked=1 from the next cycle).
    - A bad line pulses h_err and clears good_cnt.
  - LOCKED:
    - A good line clears bad_cnt.
    - A bad line pulses h_err and increments bad_cnt; on reaching UNLOCK_LINES, go to ACQUIRE with good_cnt=0 and locked=0.
  - Timeout (h_cnt reaches 1023) in any state except SEARCH: h_err pulse, go to SEARCH, locked=0 on the same edge.
- Vertical:
  - A synchronised vsync falling edge sets vs_pend.
  - At the next hsync edge: v_cnt <= 0, frame_start pulses, vs_pend clears.
  - Otherwise v_cnt increments per hsync edge and saturates at 1023.
  - vsync and hsync edges in the same cycle: v_cnt <= 0 on that edge.
- Active window:
  - Horizontal: h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1], i.e. 144..783.
  - Vertical: v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1], i.e. 35..514.
- Outputs:
  - pix_x = h_cnt-144 and pix_y = v_cnt-35, registered, so they lag h_cnt/v_cnt by one clock.
  - de = locked & in-window, registered in the same stage as pix_x/pix_y.
  - Outside the window pix_x, pix_y and de are 0.
- Widths: all subtraction is 10-bit unsigned, performed only inside the window, so no underflow.
- Reset mid-line: immediate return to the reset state; lock is reacquired from SEARCH.

Decomposition:
- Package vga_timing_pkg holds:
  - the H_*/V_* defaults, H_TOTAL and V_TOTAL;
  - active start/end constants;
  - the FSM state enum (SEARCH, ACQUIRE, LOCKED).
- Sub-module sync_fall_detect: 2-flop synchroniser plus registered falling-edge pulse, instantiated once each for hsync and vsync.

Test Plan:
- Nominal 640x480 stream from the h/v counter generator -> locked rises exactly after the 5th hsync edge.
  - Thereafter de is high 640 clocks per line on 480 lines per frame, with pix_x 0..639 and pix_y 0..479.
- Lock at first pixel -> first de pulse after lock has pix_x=0 exactly 147 clocks after the raw hsync fall.
  - The 147 clocks break down as 2 sync + 1 edge + 144 offset.
- One 799-clock line while locked -> one h_err pulse, locked stays 1.
  - Two consecutive 801-clock lines -> locked=0 after the 2nd edge and FSM in ACQUIRE.
- hsync held high for 1100 clocks while locked -> h_err pulse and locked=0 at h_cnt=1023.
  - de stays 0; relock completes after LOCK_LINES good lines.
- vsync falling in the same cycle as hsync -> frame_start on that line_start.
  - vsync falling mid-line -> frame_start on the next line_start; pix_y=0 on line 35 after it.
- rst_n asserted mid-frame -> all outputs 0 immediately (asynchronous).
  - After release, locked asserts after the 5th hsync edge.
